// File: rtl/rf_pkg.sv
// rf_pkg: default geometry of the register file and the select-width helper.
package rf_pkg;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_NUM_REGS   = 8;
   function automatic int addr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/rf_sb_if.sv
// rf_sb_if: read, write, reserve and flush ports of the scoreboarded register file.
interface rf_sb_if #(
   parameter int DW = 16,
   parameter int AW = 3
);
   logic [AW-1:0] read1regsel, read2regsel, writeregsel, rsvregsel;
   logic [DW-1:0] read1data, read2data, writedata;
   logic          read1pend, read2pend, write, rsv, flush, err;
   modport master (
      output read1regsel, read2regsel, writeregsel, writedata, write, rsvregsel, rsv, flush,
      input  read1data, read2data, read1pend, read2pend, err
   );
   modport slave (
      input  read1regsel, read2regsel, writeregsel, writedata, write, rsvregsel, rsv, flush,
      output read1data, read2data, read1pend, read2pend, err
   );
endinterface

// File: rtl/register.sv
// register: enable-loaded data register with asynchronous clear.
module register #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   always_ff @(posedge clk or posedge rst)
      if (rst) q_o <= '0;
      else if (wr_en_i) q_o <= d_i;
endmodule

// File: rtl/rf_sb.sv
// rf_sb: register file with write-to-read bypass, per-register pending bits
// for hazard detection and a sticky error flag for illegal accesses.
module rf_sb
   import rf_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_REGS   = DEF_NUM_REGS,
   parameter int ADDR_WIDTH = addr_w(NUM_REGS),
   parameter int BYPASS     = 1,
   parameter int CHECK_PEND = 1
) (
   input logic    clk,
   input logic    rst,
   rf_sb_if.slave bus
);
   localparam int N2 = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] NR = (ADDR_WIDTH + 1)'(NUM_REGS);
   // storage padded to a power of two so out-of-range entries read as constant 0
   logic [DATA_WIDTH-1:0] q [N2];
   logic [N2-1:0]         pend_q, pend_d, wr_dec, rsv_dec;
   logic                  err_q, err_d;
   logic                  wr_in, rsv_in, rd1_in, rd2_in, wr_ok, rsv_ok, hit1, hit2, rsv_hit;
   assign wr_in   = {1'b0, bus.writeregsel} < NR;
   assign rsv_in  = {1'b0, bus.rsvregsel} < NR;
   assign rd1_in  = {1'b0, bus.read1regsel} < NR;
   assign rd2_in  = {1'b0, bus.read2regsel} < NR;
   assign wr_ok   = bus.write & wr_in;
   assign rsv_ok  = bus.rsv & rsv_in & ~bus.flush;
   assign hit1    = bus.write & (bus.writeregsel == bus.read1regsel);
   assign hit2    = bus.write & (bus.writeregsel == bus.read2regsel);
   assign rsv_hit = wr_ok & (bus.writeregsel == bus.rsvregsel);
   for (genvar g = 0; g < N2; g++) begin : g_reg
      assign wr_dec[g]  = wr_ok & (bus.writeregsel == ADDR_WIDTH'(g));
      assign rsv_dec[g] = rsv_ok & (bus.rsvregsel == ADDR_WIDTH'(g));
      if (g < NUM_REGS) begin : g_store
         register #(DATA_WIDTH) u_reg (
            .clk     (clk),
            .rst     (rst),
            .wr_en_i (wr_dec[g]),
            .d_i     (bus.writedata),
            .q_o     (q[g])
         );
      end else begin : g_pad
         assign q[g] = '0;
      end
   end
   assign bus.read1data = !rd1_in ? '0 : ((BYPASS != 0) && hit1) ? bus.writedata : q[bus.read1regsel];
   assign bus.read2data = !rd2_in ? '0 : ((BYPASS != 0) && hit2) ? bus.writedata : q[bus.read2regsel];
   assign bus.read1pend = pend_q[bus.read1regsel] & ~hit1;
   assign bus.read2pend = pend_q[bus.read2regsel] & ~hit2;
   assign bus.err       = err_q;
   // a same-cycle reserve beats the write's clear: the new producer owns the register
   assign pend_d = bus.flush ? '0 : (pend_q & ~wr_dec) | rsv_dec;
   assign err_d  = err_q | (bus.write & ~wr_in) | ~rd1_in | ~rd2_in | (bus.rsv & ~rsv_in)
                 | (rsv_ok & pend_q[bus.rsvregsel] & ~rsv_hit)
                 | ((CHECK_PEND != 0) & wr_ok & ~pend_q[bus.writeregsel]);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         err_q  <= err_d;
      end
endmodule

// File: doc/rf_sb.md
# rf_sb

Parametrised register file with write-to-read bypass and a per-register pending (scoreboard) bit for pipeline hazard detection. Successor to the fixed 8×16 register file: width, depth and bypass are configurable, and each register tracks an outstanding producer. Sits in decode; the writeback stage drives the write port, and decode drives the reserve port when it issues an instruction with a destination.

## Interface
- DATA_WIDTH, 16, register width in bits
- NUM_REGS, 8, number of registers, 2..64, need not be a power of two
- ADDR_WIDTH, $clog2(NUM_REGS), select width (derived; do not override)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value
- CHECK_PEND, 1, 1 = a write to a non-pending register sets err
---
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- read1regsel  in  ADDR_WIDTH  read port 1 select
- read2regsel  in  ADDR_WIDTH  read port 2 select
- read1data  out  DATA_WIDTH  read port 1 data (combinational)
- read2data  out  DATA_WIDTH  read port 2 data (combinational)
- read1pend  out  1  selected register has an outstanding reservation
- read2pend  out  1  as read1pend, for port 2
- writeregsel  in  ADDR_WIDTH  write select
- writedata  in  DATA_WIDTH  write data
- write  in  1  write enable
- rsvregsel  in  ADDR_WIDTH  reserve select
- rsv  in  1  reserve enable: mark register pending
- flush  in  1  clear all pending bits (pipeline squash)
- err  out  1  sticky error flag

## Operation
- State: NUM_REGS data registers, NUM_REGS pending bits, err flop.
- Write: write=1, writeregsel < NUM_REGS → register loaded with writedata at the edge; its pending bit cleared.
- Reserve: rsv=1, rsvregsel < NUM_REGS, flush=0 → pending bit set at the edge.
- Write and reserve to the same register in one cycle: data written, pending ends 1 (new producer wins).
- Flush: all pending bits cleared at the edge; rsv in the same cycle ignored; a write in the same cycle still updates data.
- Read data: sel ≥ NUM_REGS → 0. BYPASS=1 and write=1 and writeregsel==sel → writedata. Otherwise the stored value.
- Read pend: pending[sel] & ~(write & writeregsel==sel). Gives 0 for out-of-range sel. Not affected by same-cycle rsv or flush.
- err set (sticky until rst) at the edge after any of:
  - active write, read or reserve with select ≥ NUM_REGS (reads always count as active);
  - rsv to an already-pending register that is not being written in the same cycle, with flush=0;
  - CHECK_PEND=1 and write to a register whose pending bit is 0.

## Timing
- Reset: data registers 0, pending bits 0, err 0; takes effect immediately and asynchronously, including mid-write.
- Reads: zero latency, combinational from select, stored state and (BYPASS) write port.
- Writes, reserves and flush: visible in stored state one cycle later.
- err: rises one cycle after the offending cycle and never falls without rst.
- No handshake; every enable is sampled once per rising edge.

## Structure
- Shared package rf_pkg holds the default DATA_WIDTH and NUM_REGS constants and a function computing ADDR_WIDTH.
- Data storage reuses the existing register sub-module (register #(DATA_WIDTH)), instantiated NUM_REGS times in a generate loop with a decoded wr_en.
- Pending bits and err are local flops in rf_sb.

## Test plan
- Reset, then read r0..r7 → all 0x0000, pend 0, err 0. rsv r3, next cycle write r3=0xBEEF; the same cycle read r3 → 0xBEEF (BYPASS), pend 0; next cycle stored value 0xBEEF.
- rsv r5 → next cycle read5pend=1. flush asserted together with rsv r6 → r5 and r6 pend 0, err 0.
- Same cycle: write r2=0x1234 and rsv r2, with r2 previously pending → r2 pend 1 next cycle, data 0x1234, err 0.
- CHECK_PEND=1: write r4 not pending → err 1 next cycle and stays 1. rsv r1 twice without a write → err 1.
- NUM_REGS=6: read sel 7 → data 0 and err set. Write sel 6 → ignored, err set.
- BYPASS=0: write r1=0xA5A5 while reading r1 → old value the same cycle, 0xA5A5 the next. Assert rst mid-sequence → all state 0 immediately.
